lut_array: RTL and testbench

Parametrised, runtime-programmable array of K-input LUTs for the CMOS fabric. It supersedes the single-stage registered mux tree. Configuration words are streamed in over a valid/ready handshake under a small load FSM. Once loaded, each of NUM_LUTS LUTs evaluates its own select vector with a registered, valid-tagged output.

---
 rtl/lut_array.sv | 136 +++++++++++++
 tb/tb_lut_array.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lut_array.sv
// Runtime-programmable array of NUM_LUTS K-input LUTs, loaded over a valid/ready config stream.
// Optional macro LUT_PIPE_EN splits each lookup into two register stages (needs LUT_K >= 2).
//
// state | meaning
// IDLE  | after reset, config not yet loaded, evaluations ignored
// LOAD  | accepting config words, cfg_ready high
// RUN   | config complete, evaluations accepted
module lut_array #(
  parameter int LUT_K     = 4,
  parameter int NUM_LUTS  = 4,
  parameter int CFG_WIDTH = 8,
  localparam int LUT_SIZE   = 1 << LUT_K,
  localparam int CFG_BITS   = NUM_LUTS * LUT_SIZE,
  localparam int CFG_WORDS  = CFG_BITS / CFG_WIDTH,
  localparam int ADDR_WIDTH = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_start,
  input  logic                        cfg_valid,
  input  logic [CFG_WIDTH-1:0]        cfg_data,
  output logic                        cfg_ready,
  output logic [ADDR_WIDTH-1:0]       cfg_addr,
  output logic                        cfg_done,
  input  logic                        eval_valid,
  input  logic [NUM_LUTS*LUT_K-1:0]   S,
  output logic [NUM_LUTS-1:0]         out,
  output logic                        out_valid
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t              state;
  logic [CFG_BITS-1:0] mem;
  logic                accept;
  logic                last_word;
  logic                eval_go;
  logic [NUM_LUTS-1:0] lookup;

  // cfg_ready is high exactly in LOAD; a word arriving with cfg_start is dropped
  assign accept    = cfg_ready && cfg_valid && !cfg_start;
  assign last_word = (cfg_addr == ADDR_WIDTH'(CFG_WORDS - 1));
  assign eval_go   = (state == RUN) && eval_valid && !cfg_start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem       <= '0;
      cfg_addr  <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (cfg_start) begin
        state     <= LOAD;
        cfg_addr  <= '0;
        cfg_ready <= 1'b1;
      end else if (accept) begin
        mem[int'(cfg_addr)*CFG_WIDTH +: CFG_WIDTH] <= cfg_data;
        if (last_word) begin
          state     <= RUN;
          cfg_addr  <= '0;
          cfg_ready <= 1'b0;
          cfg_done  <= 1'b1;
        end else begin
          cfg_addr <= cfg_addr + 1'b1;
        end
      end
    end
  end

`ifdef LUT_PIPE_EN
  localparam int LO_BITS = LUT_K / 2;
  localparam int HI_BITS = LUT_K - LO_BITS;
  localparam int GROUP   = 1 << LO_BITS;

  logic [NUM_LUTS*GROUP-1:0]   grp_d, grp_q;
  logic [NUM_LUTS*LO_BITS-1:0] lo_d, lo_q;
  logic                        stage_v;

  // first stage picks the 2^LO_BITS-bit slice addressed by the upper select bits
  always_comb begin
    grp_d = '0;
    lo_d  = '0;
    for (int j = 0; j < NUM_LUTS; j++) begin
      grp_d[j*GROUP +: GROUP] =
        mem[j*LUT_SIZE + int'(S[j*LUT_K+LO_BITS +: HI_BITS])*GROUP +: GROUP];
      lo_d[j*LO_BITS +: LO_BITS] = S[j*LUT_K +: LO_BITS];
    end
  end

  always_comb begin
    lookup = '0;
    for (int j = 0; j < NUM_LUTS; j++)
      lookup[j] = grp_q[j*GROUP + int'(lo_q[j*LO_BITS +: LO_BITS])];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grp_q     <= '0;
      lo_q      <= '0;
      stage_v   <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      stage_v <= eval_go;
      if (eval_go) begin
        grp_q <= grp_d;
        lo_q  <= lo_d;
      end
      // a restart or leaving RUN kills whatever sits in the first stage
      out_valid <= stage_v && (state == RUN) && !cfg_start;
      if (stage_v && (state == RUN) && !cfg_start)
        out <= lookup;
    end
  end
`else
  always_comb begin
    lookup = '0;
    for (int j = 0; j < NUM_LUTS; j++)
      lookup[j] = mem[j*LUT_SIZE + int'(S[j*LUT_K +: LUT_K])];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= eval_go;
      if (eval_go)
        out <= lookup;
    end
  end
`endif

endmodule

// File: tb/tb_lut_array.sv
// Directed bench for lut_array with default parameters (K=4, N=4, W=8).
module tb_lut_array;

`ifdef LUT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic        cfg_valid;
  logic [7:0]  cfg_data;
  logic        cfg_ready;
  logic [2:0]  cfg_addr;
  logic        cfg_done;
  logic        eval_valid;
  logic [15:0] S;
  logic [3:0]  out;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  words [8] = '{8'h96, 8'h69, 8'h00, 8'h80, 8'hFE, 8'hFF, 8'h01, 8'h00};
  logic [15:0] sv    [3] = '{16'hFFFF, 16'h0000, 16'h7777};
  logic [3:0]  ev    [3] = '{4'b0110, 4'b1000, 4'b0101};

  lut_array dut (
    .clock(clock), .reset(reset),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_done(cfg_done),
    .eval_valid(eval_valid), .S(S), .out(out), .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input bit gaps);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hAA;
    tick;
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk("load_ready", cfg_ready, 1);
    chk("load_addr0", cfg_addr, 0);
    for (int i = 0; i < 8; i++) begin
      if (gaps && (i % 3 == 1)) begin
        cfg_valid = 1'b0;
        tick;
        chk("gap_hold", cfg_addr, i);
      end
      cfg_valid = 1'b1; cfg_data = words[i];
      chk("addr_step", cfg_addr, i);
      chk("done_low", cfg_done, 0);
      tick;
    end
    cfg_valid = 1'b0;
    chk("done_pulse", cfg_done, 1);
    chk("addr_wrap", cfg_addr, 0);
    chk("ready_off", cfg_ready, 0);
  endtask

  task automatic eval_run;
    for (int i = 0; i < 3 + LAT - 1; i++) begin
      if (i < 3) begin
        eval_valid = 1'b1; S = sv[i];
      end else begin
        eval_valid = 1'b0;
      end
      tick;
      if (i == 0) chk("done_once", cfg_done, 0);
      if (i >= LAT - 1) begin
        chk("eval_out", out, ev[i-LAT+1]);
        chk("eval_valid", out_valid, 1);
      end
    end
    eval_valid = 1'b0;
    tick;
    chk("idle_valid", out_valid, 0);
    chk("idle_hold", out, 4'b0101);
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    eval_valid = 1'b0; S = '0;
    repeat (2) tick;
    chk("rst_ready", cfg_ready, 0);
    chk("rst_addr", cfg_addr, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    reset = 1'b0;

    eval_valid = 1'b1; S = 16'hFFFF;
    tick;
    eval_valid = 1'b0;
    chk("idle_eval_out", out, 0);
    chk("idle_eval_valid", out_valid, 0);
    chk("idle_ready", cfg_ready, 0);

    load(1'b0);
    eval_run;

    // partial load with gaps, then restart and full load with gaps
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b0;
      tick;
      cfg_valid = 1'b1; cfg_data = 8'h55;
      tick;
    end
    cfg_valid = 1'b0;
    chk("part_addr", cfg_addr, 3);
    load(1'b1);
    eval_run;

    // start and eval together: start wins
    cfg_start = 1'b1; eval_valid = 1'b1; S = 16'hFFFF;
    tick;
    cfg_start = 1'b0;
    chk("coll_valid", out_valid, 0);
    chk("coll_ready", cfg_ready, 1);
    chk("coll_hold", out, 4'b0101);
    tick;
    eval_valid = 1'b0;
    chk("load_eval_ign", out_valid, 0);

    // reset after 5 of 8 words
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1; cfg_data = words[i];
      tick;
    end
    cfg_valid = 1'b0;
    chk("mid_addr", cfg_addr, 5);
    #2 reset = 1'b1;
    #1;
    chk("async_ready", cfg_ready, 0);
    chk("async_addr", cfg_addr, 0);
    chk("async_out", out, 0);
    reset = 1'b0;
    eval_valid = 1'b1; S = 16'h0000;
    tick;
    eval_valid = 1'b0;
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_out", out, 0);
    chk("post_rst_ready", cfg_ready, 0);

    load(1'b0);
    eval_run;

    // reset with an evaluation in flight
    eval_valid = 1'b1; S = 16'hFFFF;
    tick;
    eval_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("flight_out", out, 0);
    chk("flight_valid", out_valid, 0);
    reset = 1'b0;
    tick;
    chk("flight_discard", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
